// File: rtl/mem_burst_adapter.sv
// mem_burst_adapter
// Avalon-MM burst slave in front of a single-port on-chip RAM (registered
// address, unregistered q). Burst reads and writes are broken into one RAM
// access per cycle; every RAM-side output and every Avalon output is a flop.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   avs_address            word address of the first beat
//   avs_burstcount         beats in the burst (0 is treated as 1)
//   avs_read / avs_write   read command / write beat
//   avs_writedata          write data
//   avs_byteenable         byte lanes of a write beat
//   avs_waitrequest        high while a read burst is being issued
//   avs_readdata           read data
//   avs_readdatavalid      avs_readdata valid this cycle
//   mem_*                  RAM address/byteenable/chipselect/write/writedata/clken
//   mem_readdata           RAM q, valid one cycle after the address
module mem_burst_adapter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BE_W    = 4,
  parameter int unsigned BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic [BURST_W-1:0] avs_burstcount,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [DATA_W-1:0]  avs_writedata,
  input  logic [BE_W-1:0]    avs_byteenable,
  output logic               avs_waitrequest,
  output logic [DATA_W-1:0]  avs_readdata,
  output logic               avs_readdatavalid,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BE_W-1:0]    mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic               mem_clken,
  input  logic [DATA_W-1:0]  mem_readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // One RAM access as presented on the mem_* pins
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } mem_cmd_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [BURST_W-1:0] burst_eff;
  mem_cmd_t           cmd_q, cmd_d;
  logic               rd_pend1_q, rd_pend1_d;
  logic               rd_pend2_q, rd_pend2_d;
  logic               waitrequest_q, waitrequest_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               readdatavalid_q, readdatavalid_d;
  logic               clken_q, clken_d;

  // State, address/beat counters, RAM command and read-valid pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      cmd_q           <= '0;
      rd_pend1_q      <= 1'b0;
      rd_pend2_q      <= 1'b0;
      waitrequest_q   <= 1'b1;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      clken_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      cmd_q           <= cmd_d;
      rd_pend1_q      <= rd_pend1_d;
      rd_pend2_q      <= rd_pend2_d;
      waitrequest_q   <= waitrequest_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      clken_q         <= clken_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    remaining_d      = remaining_q;
    cmd_d            = cmd_q;
    cmd_d.chipselect = 1'b0;
    cmd_d.write      = 1'b0;
    rd_pend1_d       = 1'b0;
    burst_eff        = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;

    unique case (state_q)
      S_IDLE: begin
        // The first beat is issued straight from IDLE so the command-to-data
        // latency is three cycles; remaining counts the beats still to issue.
        if (avs_read) begin
          cmd_d.address    = avs_address;
          cmd_d.byteenable = '1;
          cmd_d.chipselect = 1'b1;
          rd_pend1_d       = 1'b1;
          addr_d           = avs_address + ADDR_W'(1);
          remaining_d      = burst_eff - BURST_W'(1);
          state_d          = S_READ;
        end else if (avs_write) begin
          cmd_d.address    = avs_address;
          cmd_d.byteenable = avs_byteenable;
          cmd_d.writedata  = avs_writedata;
          cmd_d.chipselect = 1'b1;
          cmd_d.write      = 1'b1;
          addr_d           = avs_address + ADDR_W'(1);
          remaining_d      = burst_eff - BURST_W'(1);
          state_d          = (burst_eff == BURST_W'(1)) ? S_IDLE : S_WRITE;
        end
      end

      S_READ: begin
        if (remaining_q != '0) begin
          cmd_d.address    = addr_q;
          cmd_d.byteenable = '1;
          cmd_d.chipselect = 1'b1;
          rd_pend1_d       = 1'b1;
          addr_d           = addr_q + ADDR_W'(1);
          remaining_d      = remaining_q - BURST_W'(1);
        end
        // Leave while the last beat is issued so a following command lands
        // right behind it with no bubble on readdatavalid.
        if (remaining_q <= BURST_W'(1)) begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        // avs_read here is a protocol violation and is ignored
        if (remaining_q == '0) begin
          state_d = S_IDLE;
        end else if (avs_write) begin
          cmd_d.address    = addr_q;
          cmd_d.byteenable = avs_byteenable;
          cmd_d.writedata  = avs_writedata;
          cmd_d.chipselect = 1'b1;
          cmd_d.write      = 1'b1;
          addr_d           = addr_q + ADDR_W'(1);
          remaining_d      = remaining_q - BURST_W'(1);
          if (remaining_q == BURST_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Address on the RAM pins in T, q valid in T+1, registered out in T+2
    rd_pend2_d      = rd_pend1_q;
    readdatavalid_d = rd_pend2_q;
    readdata_d      = rd_pend2_q ? mem_readdata : readdata_q;

    waitrequest_d   = (state_d == S_READ);
    clken_d         = 1'b1;
  end

  assign avs_waitrequest   = waitrequest_q;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign mem_address       = cmd_q.address;
  assign mem_byteenable    = cmd_q.byteenable;
  assign mem_chipselect    = cmd_q.chipselect;
  assign mem_write         = cmd_q.write;
  assign mem_writedata     = cmd_q.writedata;
  assign mem_clken         = clken_q;

endmodule

// File: tb/tb_mem_burst_adapter.sv
// Self-checking bench for mem_burst_adapter: a behavioural RAM on the mem_*
// side, a word-level reference memory updated per accepted write beat, and a
// queue of expected read data filled per accepted read command.
module tb_mem_burst_adapter;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned DEPTH   = 1024;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ADDR_W-1:0]  avs_address;
  logic [BURST_W-1:0] avs_burstcount;
  logic               avs_read;
  logic               avs_write;
  logic [DATA_W-1:0]  avs_writedata;
  logic [BE_W-1:0]    avs_byteenable;
  logic               avs_waitrequest;
  logic [DATA_W-1:0]  avs_readdata;
  logic               avs_readdatavalid;
  logic [ADDR_W-1:0]  mem_address;
  logic [BE_W-1:0]    mem_byteenable;
  logic               mem_chipselect;
  logic               mem_write;
  logic [DATA_W-1:0]  mem_writedata;
  logic               mem_clken;
  logic [DATA_W-1:0]  mem_readdata;

  always #5 clk = ~clk;

  mem_burst_adapter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_address      (avs_address),
    .avs_burstcount   (avs_burstcount),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_byteenable   (avs_byteenable),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // Behavioural on-chip RAM: registered address, unregistered q
  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] rd_addr_log [$];
  int                rdv_cyc [$];
  logic [DATA_W-1:0] last_rdata;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdv_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: read data against the expected queue, count RAM writes, log read addresses
  always @(negedge clk) begin
    if (reset_n) begin
      if (avs_readdatavalid) begin
        rdv_cnt++;
        rdv_cyc.push_back(cyc);
        last_rdata = avs_readdata;
        if (exp_q.size() == 0) check("spurious_rdv", 32'd1, 32'd0);
        else check("rdata", avs_readdata, exp_q.pop_front());
      end
      if (mem_chipselect && mem_write) wr_cnt++;
      if (mem_chipselect && !mem_write) rd_addr_log.push_back(mem_address);
    end
  end

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] d,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (avs_waitrequest) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check(tag, 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after acceptance
  task automatic send_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc);
    int n = (bc == 0) ? 1 : int'(bc);
    avs_address = a; avs_burstcount = bc; avs_read = 1'b1; avs_write = 1'b0;
    wait_ready("read_wait_timeout");
    @(negedge clk);
    avs_read = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[ADDR_W'(int'(a) + i)]);
  endtask

  task automatic send_write(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc,
                            input logic [DATA_W-1:0] d [8], input logic [BE_W-1:0] be [8],
                            input int gmin, input int gmax);
    int n = (bc == 0) ? 1 : int'(bc);
    logic [ADDR_W-1:0] wa;
    avs_address = a; avs_burstcount = bc; avs_read = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        int ng = $urandom_range(gmax, gmin);
        avs_write = 1'b0;
        repeat (ng) @(negedge clk);
      end
      avs_write = 1'b1; avs_writedata = d[k]; avs_byteenable = be[k];
      wait_ready("write_wait_timeout");
      @(negedge clk);
      wa = ADDR_W'(int'(a) + k);
      ref_mem[wa] = merge(ref_mem[wa], d[k], be[k]);
    end
    avs_write = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] d [8];
    logic [BE_W-1:0]   be [8];
    reset_n = 1'b0;
    avs_address = '0; avs_burstcount = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_waitrequest", avs_waitrequest, 1);
    check("rst_rdv", avs_readdatavalid, 0);
    check("rst_readdata", avs_readdata, 0);
    check("rst_mem_cs", mem_chipselect, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_clken", mem_clken, 0);
    check("rst_mem_address", 32'(mem_address), 0);
    reset_n = 1'b1;
    #1 check("rel_clken_before_edge", mem_clken, 0);
    @(negedge clk);
    check("rel_waitrequest", avs_waitrequest, 0);
    check("rel_clken", mem_clken, 1);

    // Single read: latency and waitrequest profile
    ram[10'h010] = 32'hDEADBEEF; ref_mem[10'h010] = 32'hDEADBEEF;
    send_read(10'h010, 4'd1);
    check("t1_wait_n1", avs_waitrequest, 1);
    check("t1_rdv_n1", avs_readdatavalid, 0);
    @(negedge clk);
    check("t1_wait_n2", avs_waitrequest, 0);
    check("t1_rdv_n2", avs_readdatavalid, 0);
    @(negedge clk);
    check("t1_rdv_n3", avs_readdatavalid, 1);
    check("t1_data_n3", avs_readdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_rdv_n4", avs_readdatavalid, 0);

    // Read burst wrapping at the top of the address space
    for (int i = 0; i < 4; i++) begin
      ram[10'(1022 + i)] = 32'(i + 1);
      ref_mem[10'(1022 + i)] = 32'(i + 1);
    end
    rd_addr_log.delete(); rdv_cyc.delete(); rdv_cnt = 0;
    send_read(10'h3FE, 4'd4);
    repeat (6) @(negedge clk);
    check("t2_naddr", rd_addr_log.size(), 4);
    if (rd_addr_log.size() == 4) begin
      check("t2_addr0", 32'(rd_addr_log[0]), 32'h3FE);
      check("t2_addr1", 32'(rd_addr_log[1]), 32'h3FF);
      check("t2_addr2", 32'(rd_addr_log[2]), 32'h000);
      check("t2_addr3", 32'(rd_addr_log[3]), 32'h001);
    end
    check("t2_nrdv", rdv_cnt, 4);
    if (rdv_cyc.size() == 4) check("t2_consecutive", rdv_cyc[3] - rdv_cyc[0], 3);
    check("t2_last", last_rdata, 32'd4);

    // Write burst with idle gaps and partial byte enables
    for (int i = 0; i < 3; i++) begin
      ram[10'h020 + 10'(i)] = 32'hFFFFFFFF;
      ref_mem[10'h020 + 10'(i)] = 32'hFFFFFFFF;
    end
    for (int i = 0; i < 8; i++) begin d[i] = '0; be[i] = 4'hF; end
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC; be[1] = 4'h3;
    wr_cnt = 0;
    send_write(10'h020, 4'd3, d, be, 1, 1);
    repeat (2) @(negedge clk);
    check("t3_ram0", ram[10'h020], 32'h0000000A);
    check("t3_ram1", ram[10'h021], 32'hFFFF000B);
    check("t3_ram2", ram[10'h022], 32'h0000000C);
    check("t3_nwrites", wr_cnt, 3);

    // Back-to-back reads, then burstcount 0
    rdv_cyc.delete(); rdv_cnt = 0;
    send_read(10'h100, 4'd2);
    send_read(10'h200, 4'd2);
    repeat (6) @(negedge clk);
    check("t4_nrdv", rdv_cnt, 4);
    if (rdv_cyc.size() == 4) check("t4_consecutive", rdv_cyc[3] - rdv_cyc[0], 3);
    rdv_cnt = 0; rd_addr_log.delete();
    send_read(10'h300, 4'd0);
    repeat (6) @(negedge clk);
    check("t4_bc0_nrdv", rdv_cnt, 1);
    check("t4_bc0_naddr", rd_addr_log.size(), 1);

    // Write then read of the same address
    d[0] = 32'h55AA55AA; be[0] = 4'hF;
    send_write(10'h005, 4'd1, d, be, 0, 0);
    send_read(10'h005, 4'd1);
    repeat (4) @(negedge clk);
    check("t5_rdata", last_rdata, 32'h55AA55AA);

    // Randomized mix of read and write bursts
    for (int t = 0; t < 60; t++) begin
      logic [ADDR_W-1:0]  a  = ADDR_W'($urandom);
      logic [BURST_W-1:0] bc = BURST_W'($urandom_range(8, 0));
      if ($urandom_range(1, 0) == 1) begin
        send_read(a, bc);
      end else begin
        for (int i = 0; i < 8; i++) begin d[i] = $urandom; be[i] = BE_W'($urandom); end
        send_write(a, bc, d, be, 0, 2);
      end
    end
    repeat (8) @(negedge clk);
    check("rand_drain", exp_q.size(), 0);

    // Reset during the second beat of a burst-8 write
    ram[10'h081] = 32'hCAFEF00D; ref_mem[10'h081] = 32'hCAFEF00D;
    avs_address = 10'h080; avs_burstcount = 4'd8; avs_write = 1'b1;
    avs_writedata = 32'h11111111; avs_byteenable = 4'hF;
    @(negedge clk);
    avs_writedata = 32'h22222222;
    @(negedge clk);
    reset_n = 1'b0; avs_write = 1'b0;
    #1 check("t6w_mem_write", mem_write, 0);
    check("t6w_cs", mem_chipselect, 0);
    ref_mem[10'h080] = 32'h11111111;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6w_ram0", ram[10'h080], 32'h11111111);
    check("t6w_ram1", ram[10'h081], 32'hCAFEF00D);

    // Reset during the second beat of a burst-8 read
    send_read(10'h040, 4'd8);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6r_waitrequest", avs_waitrequest, 1);
    check("t6r_rdv", avs_readdatavalid, 0);
    check("t6r_readdata", avs_readdata, 0);
    check("t6r_cs", mem_chipselect, 0);
    check("t6r_clken", mem_clken, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("t6r_rdv_in_reset", avs_readdatavalid, 0);
    rdv_cnt = 0; wr_cnt = 0;
    reset_n = 1'b1;
    @(negedge clk);
    check("t6r_rel_wait", avs_waitrequest, 0);
    check("t6r_rel_clken", mem_clken, 1);
    repeat (8) @(negedge clk);
    check("t6r_no_rdv", rdv_cnt, 0);
    check("t6r_no_write", wr_cnt, 0);

    // Whole-memory comparison against the reference
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== ref_mem[i]) check($sformatf("ram_%0h", i), ram[i], ref_mem[i]);
    end
    check("ram_sample", ram[10'h005], ref_mem[10'h005]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
